// File: rtl/fnd_scan_ctrl_if.sv
// Display-side bundle for the FND scan controller: scan strobe, frame data
// and control coming in, anode/segment drive and digit index going out.
interface fnd_scan_ctrl_if;
    logic        i_tick;
    logic        i_enable;
    logic [15:0] i_bcd;
    logic [3:0]  i_dp;
    logic        i_blank_lz;
    logic [3:0]  o_fnd_comm;
    logic [7:0]  o_fnd_font;
    logic [1:0]  o_digit_sel;

    // Upstream side: supplies the frame and strobes, watches the pin drive.
    modport master (
        output i_tick, i_enable, i_bcd, i_dp, i_blank_lz,
        input  o_fnd_comm, o_fnd_font, o_digit_sel
    );

    // Controller side.
    modport slave (
        input  i_tick, i_enable, i_bcd, i_dp, i_blank_lz,
        output o_fnd_comm, o_fnd_font, o_digit_sel
    );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller. Each accepted scan tick
// moves to the next digit, holds every anode off for BLANK_CYCLES clocks to
// avoid ghosting, then lights the digit. A new frame is captured only when
// the scan wraps to digit 0 so a digit never tears mid-frame.
module fnd_scan_ctrl #(
    parameter int BLANK_CYCLES = 2   // legal 1..255
) (
    input  logic           clk,
    input  logic           reset,
    fnd_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  comm_q, comm_d;
    logic [7:0]  font_q, font_d;
    logic [15:0] frame_bcd_q, frame_bcd_d;
    logic [3:0]  frame_dp_q, frame_dp_d;

    logic        blank_done;
    logic [3:0]  digit;
    logic        lz_blank;
    logic [7:0]  font_lit;

    assign blank_done = (state_q == BLANK) && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next state: disable beats tick, tick beats the blanking timeout.
    always_comb begin
        state_d = state_q;
        if (!bus.i_enable) begin
            state_d = IDLE;
        end else if (bus.i_tick) begin
            state_d = BLANK;
        end else if (blank_done) begin
            state_d = SHOW;
        end
    end

    // Segment pattern for the digit about to be lit, from the captured frame.
    always_comb begin
        digit = frame_bcd_q[{idx_q, 2'b00} +: 4];

        lz_blank = 1'b0;
        case (idx_q)
            2'd3:    lz_blank = (frame_bcd_q[15:12] == 4'd0);
            2'd2:    lz_blank = (frame_bcd_q[15:8]  == 8'd0);
            2'd1:    lz_blank = (frame_bcd_q[15:4]  == 12'd0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank & bus.i_blank_lz;

        case (digit)
            4'd0:    font_lit = 8'hC0;
            4'd1:    font_lit = 8'hF9;
            4'd2:    font_lit = 8'hA4;
            4'd3:    font_lit = 8'hB0;
            4'd4:    font_lit = 8'h99;
            4'd5:    font_lit = 8'h92;
            4'd6:    font_lit = 8'h82;
            4'd7:    font_lit = 8'hF8;
            4'd8:    font_lit = 8'h80;
            4'd9:    font_lit = 8'h90;
            default: font_lit = 8'hBF;   // non-BCD shows a dash
        endcase

        if (lz_blank) begin
            font_lit = 8'hFF;
        end
        // Decimal point survives blanking and invalid digits.
        if (frame_dp_q[idx_q]) begin
            font_lit[7] = 1'b0;
        end
    end

    // Output/datapath next values for the registered pin drive.
    always_comb begin
        // NOTE: every target gets a hold default first, so no path infers a latch.
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        comm_d      = comm_q;
        font_d      = font_q;
        frame_bcd_d = frame_bcd_q;
        frame_dp_d  = frame_dp_q;

        if (!bus.i_enable) begin
            idx_d  = 2'd3;
            cnt_d  = 8'd0;
            comm_d = 4'hF;
            font_d = 8'hFF;
        end else if (bus.i_tick) begin
            idx_d  = idx_q + 2'd1;
            cnt_d  = 8'd0;
            comm_d = 4'hF;
            font_d = 8'hFF;
            if (idx_q == 2'd3) begin
                frame_bcd_d = bus.i_bcd;
                frame_dp_d  = bus.i_dp;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    comm_d = 4'hF;
                    font_d = 8'hFF;
                end
                BLANK: begin
                    if (cnt_q == CNT_LAST) begin
                        comm_d        = 4'hF;
                        comm_d[idx_q] = 1'b0;
                        font_d        = font_lit;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: ;   // SHOW holds until the next tick or disable
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= 2'd3;
            cnt_q       <= 8'd0;
            comm_q      <= 4'hF;
            font_q      <= 8'hFF;
            // NOTE: frame storage is reset too, so the first lit digit is never X.
            frame_bcd_q <= 16'd0;
            frame_dp_q  <= 4'd0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            comm_q      <= comm_d;
            font_q      <= font_d;
            frame_bcd_q <= frame_bcd_d;
            frame_dp_q  <= frame_dp_d;
        end
    end

    assign bus.o_fnd_comm  = comm_q;
    assign bus.o_fnd_font  = font_q;
    assign bus.o_digit_sel = idx_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl. A behavioural model tracks which
// digit is selected, how many clocks have passed since the last accepted
// tick and the captured frame; the pin drive is derived from those every
// cycle and compared against the DUT one time unit after each rising edge.
module tb_fnd_scan_ctrl;

    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic reset;

    fnd_scan_ctrl_if bus ();

    fnd_scan_ctrl #(.BLANK_CYCLES(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int          m_idx;
    bit          m_active;   // a tick has been accepted since reset/disable
    int          m_age;      // clocks since that tick, saturating at BLANK
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    logic [7:0]  m_font;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
    function automatic logic [7:0] model_font(input int idx, input logic [15:0] frame,
                                               input logic [3:0] dpv, input logic lz);
        logic [15:0] upper;
        logic [7:0]  f;
        upper = frame >> (4 * idx);
        if (lz && idx > 0 && upper == 16'd0) f = 8'hFF;
        else                                 f = seg_of(int'(upper & 16'hF));
        if (dpv[idx]) f[7] = 1'b0;
        return f;
    endfunction

    function automatic void model_reset();
        m_idx    = 3;
        m_active = 1'b0;
        m_age    = 0;
        m_bcd    = 16'd0;
        m_dp     = 4'd0;
        m_font   = 8'hFF;
    endfunction

    function automatic void model_edge();
        if (!bus.i_enable) begin
            m_idx    = 3;
            m_active = 1'b0;
        end else if (bus.i_tick) begin
            m_idx = (m_idx + 1) % 4;
            if (m_idx == 0) begin
                m_bcd = bus.i_bcd;
                m_dp  = bus.i_dp;
            end
            m_active = 1'b1;
            m_age    = 0;
        end else if (m_active && m_age < BLANK) begin
            m_age++;
            if (m_age == BLANK) m_font = model_font(m_idx, m_bcd, m_dp, bus.i_blank_lz);
        end
    endfunction

    task automatic compare(input string tag);
        bit         lit;
        logic [3:0] exp_comm;
        logic [7:0] exp_font;
        lit      = m_active && (m_age >= BLANK);
        exp_comm = 4'hF;
        exp_font = 8'hFF;
        if (lit) begin
            exp_comm[m_idx] = 1'b0;
            exp_font        = m_font;
        end
        check({tag, ".comm"}, 32'(bus.o_fnd_comm),  32'(exp_comm));
        check({tag, ".font"}, 32'(bus.o_fnd_font),  32'(exp_font));
        check({tag, ".sel"},  32'(bus.o_digit_sel), 32'(m_idx));
    endtask

    // One clock: advance the model on the edge, check shortly after it.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        compare(tag);
    endtask

    task automatic tick_gap(input string tag, input int gap);
        bus.i_tick = 1'b1;
        cyc(tag);
        bus.i_tick = 1'b0;
        repeat (gap - 1) cyc(tag);
    endtask

    // Assert reset away from any edge and check the outputs drop at once.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare({tag, ".async"});
        repeat (3) cyc(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.i_tick     = 1'b0;
        bus.i_enable   = 1'b1;
        bus.i_bcd      = 16'h0000;
        bus.i_dp       = 4'h0;
        bus.i_blank_lz = 1'b0;
        model_reset();
        #1;
        compare("reset");
        repeat (2) cyc("reset");
        @(negedge clk);
        reset = 1'b0;

        // Enabled but no tick: stays dark on digit 3.
        repeat (100) cyc("idle");

        // Plain scan of 1234, two full frames.
        bus.i_bcd = 16'h1234;
        repeat (8) tick_gap("scan1234", 10);

        // Leading-zero blanking with a decimal point on a blanked digit.
        bus.i_bcd      = 16'h0005;
        bus.i_dp       = 4'b0100;
        bus.i_blank_lz = 1'b1;
        repeat (4) tick_gap("lz0005", 10);

        // Invalid BCD dash, then a mid-frame change that must wait for wrap.
        bus.i_bcd      = 16'h00A0;
        bus.i_dp       = 4'b0000;
        bus.i_blank_lz = 1'b0;
        repeat (2) tick_gap("dash", 10);
        bus.i_bcd = 16'h9999;
        repeat (2) tick_gap("tearfree", 10);
        repeat (4) tick_gap("newframe", 10);

        // Back-to-back ticks keep every anode off.
        bus.i_tick = 1'b1;
        repeat (5) cyc("b2b");
        bus.i_tick = 1'b0;
        repeat (6) cyc("b2b");

        // Disable while blanking, then the next tick lights digit 0.
        bus.i_tick = 1'b1;
        cyc("dis");
        bus.i_tick   = 1'b0;
        bus.i_enable = 1'b0;
        cyc("dis");
        bus.i_enable = 1'b1;
        repeat (3) cyc("dis");
        tick_gap("dis", 10);

        // Disable and tick together: disable wins.
        bus.i_tick   = 1'b1;
        bus.i_enable = 1'b0;
        cyc("disprio");
        bus.i_tick   = 1'b0;
        bus.i_enable = 1'b1;
        repeat (3) cyc("disprio");

        // Reset while digit 2 is shown; first tick afterwards lights digit 0.
        bus.i_bcd = 16'h4321;
        repeat (3) tick_gap("prereset", 10);
        pulse_reset("midreset");
        repeat (2) cyc("postreset");
        tick_gap("postreset", 10);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) begin
                logic [15:0] v;
                for (int k = 0; k < 4; k++)
                    v[4*k +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
                bus.i_bcd = v;
                bus.i_dp  = 4'($urandom % 16);
            end
            if (n % 97 == 0) bus.i_blank_lz = 1'($urandom % 2);
            bus.i_tick   = ($urandom % 6 == 0);
            bus.i_enable = ($urandom % 60 != 0);
            cyc("rand");
        end
        bus.i_tick   = 1'b0;
        bus.i_enable = 1'b1;
        repeat (4) cyc("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
